// File: rtl/cmd_packet_rx_pkg.sv
// Shared constants, field offsets and state encoding for the command packet framer.
// Imported by the framer and by the loaders that consume its packets.
package cmd_packet_rx_pkg;

    localparam logic [7:0] SOF_BYTE = 8'hA5;
    localparam logic [7:0] OP_VERT  = 8'h01;
    localparam logic [7:0] OP_EDGE  = 8'h02;

    localparam int B_SOF   = 0;
    localparam int B_LEN   = 1;
    localparam int B_OP    = 2;
    localparam int B_COUNT = 3;
    localparam int B_START = 4;
    localparam int B_PAY_B = 5;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_BODY,
        ST_DISPATCH,
        ST_WAIT
    } state_t;

    // LEN covers opcode..checksum, so at least 2; SOF+LEN+body must fit the buffer.
    function automatic logic len_ok(input logic [7:0] len, input int unsigned psize);
        return (len >= 8'd2) && ((32'(len) + 32'd2) <= psize);
    endfunction

endpackage

// File: rtl/cmd_packet_rx_if.sv
// Byte-stream input and packet-dispatch bundle of the command packet framer.
// master = host/loader side, slave = framer side.
interface cmd_packet_rx_if #(
    parameter int PACKET_SIZE = 256,
    parameter int NUM_DST     = 4
);
    logic [7:0]               rx_data;
    logic                     rx_valid;
    logic                     rx_ready;
    logic [8*PACKET_SIZE-1:0] begin_packet;
    logic [7:0]               begin_len;
    logic [NUM_DST-1:0]       begin_req_pulse;
    logic [NUM_DST-1:0]       dst_busy;
    logic                     BUSY;
    logic                     err_len;
    logic                     err_csum;
    logic                     err_opcode;
    logic                     err_timeout;

    modport master (
        output rx_data, rx_valid, dst_busy,
        input  rx_ready, begin_packet, begin_len, begin_req_pulse,
        input  BUSY, err_len, err_csum, err_opcode, err_timeout
    );

    modport slave (
        input  rx_data, rx_valid, dst_busy,
        output rx_ready, begin_packet, begin_len, begin_req_pulse,
        output BUSY, err_len, err_csum, err_opcode, err_timeout
    );
endinterface

// File: rtl/cmd_packet_rx.sv
// Command packet framer: hunts SOF, buffers one frame, checks LEN and checksum,
// dispatches by opcode and holds the packet until the chosen loader goes idle.
module cmd_packet_rx #(
    parameter int unsigned PACKET_SIZE = 256,
    parameter int unsigned NUM_DST     = 4,
    parameter logic [7:0]  SOF_BYTE    = cmd_packet_rx_pkg::SOF_BYTE,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input logic            CLK,
    input logic            rst,
    cmd_packet_rx_if.slave bus
);
    import cmd_packet_rx_pkg::*;

    state_t state, state_nxt;

    logic [8*PACKET_SIZE-1:0] pkt;
    logic [7:0]   len_q, idx, acc, op, din;
    logic [8:0]   last_idx;
    logic [31:0]  tcnt;
    logic [NUM_DST-1:0] hot;
    logic accept, last, in_frame, tmo;
    logic bad_len, bad_csum, bad_op, busy_sel;
    logic e_len, e_csum, e_op, e_tmo;

    assign din      = bus.rx_data;
    assign accept   = bus.rx_valid && bus.rx_ready;
    assign op       = pkt[8*B_OP +: 8];
    assign last_idx = {1'b0, len_q} + 9'd1;
    assign last     = ({1'b0, idx} == last_idx);
    assign in_frame = (state == ST_LEN) || (state == ST_BODY);
    assign tmo      = !accept && (tcnt == TIMEOUT_CYC - 1);
    assign bad_len  = !len_ok(din, PACKET_SIZE);
    assign bad_csum = (acc != din);
    assign bad_op   = (32'(op) >= NUM_DST);
    assign busy_sel = |(bus.dst_busy & hot);

    always_comb begin
        hot = '0;
        for (int k = 0; k < NUM_DST; k++) hot[k] = (32'(op) == 32'(k));
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state <= ST_HUNT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_HUNT: begin
                if (accept && din == SOF_BYTE) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (accept)   state_nxt = bad_len ? ST_HUNT : ST_BODY;
                else if (tmo) state_nxt = ST_HUNT;
            end
            ST_BODY: begin
                if (accept && last)
                    state_nxt = (bad_csum || bad_op) ? ST_HUNT : ST_DISPATCH;
                else if (tmo)
                    state_nxt = ST_HUNT;
            end
            ST_DISPATCH: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (!busy_sel) state_nxt = ST_HUNT;
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

    always_comb begin
        bus.rx_ready        = 1'b0;
        bus.BUSY            = 1'b1;
        bus.begin_req_pulse = '0;
        unique case (state)
            ST_HUNT: begin
                bus.rx_ready = 1'b1;
                bus.BUSY     = 1'b0;
            end
            ST_LEN, ST_BODY: bus.rx_ready = 1'b1;
            ST_DISPATCH:     bus.begin_req_pulse = hot;
            ST_WAIT:         bus.rx_ready = 1'b0;
            default:         bus.BUSY = 1'b1;
        endcase
    end

    // Packet buffer, checksum and timeout; only written while collecting a frame.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            pkt    <= '0;
            len_q  <= '0;
            idx    <= '0;
            acc    <= '0;
            tcnt   <= '0;
            e_len  <= 1'b0;
            e_csum <= 1'b0;
            e_op   <= 1'b0;
            e_tmo  <= 1'b0;
        end else begin
            e_len  <= 1'b0;
            e_csum <= 1'b0;
            e_op   <= 1'b0;
            e_tmo  <= 1'b0;
            tcnt   <= (accept || !in_frame) ? 32'd0 : tcnt + 32'd1;
            unique case (state)
                ST_HUNT: begin
                    if (accept && din == SOF_BYTE) begin
                        pkt <= '0;
                        pkt[8*B_SOF +: 8] <= din;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        pkt[8*B_LEN +: 8] <= din;
                        len_q <= din;
                        idx   <= 8'd2;
                        acc   <= 8'd0;
                        e_len <= bad_len;
                    end else begin
                        e_tmo <= tmo;
                    end
                end
                ST_BODY: begin
                    if (accept) begin
                        pkt[8*idx +: 8] <= din;
                        idx <= idx + 8'd1;
                        if (last) begin
                            e_csum <= bad_csum;
                            e_op   <= !bad_csum && bad_op;
                        end else begin
                            acc <= acc ^ din;
                        end
                    end else begin
                        e_tmo <= tmo;
                    end
                end
                default: tcnt <= 32'd0;
            endcase
        end
    end

    assign bus.begin_packet = pkt;
    assign bus.begin_len    = len_q;
    assign bus.err_len      = e_len;
    assign bus.err_csum     = e_csum;
    assign bus.err_opcode   = e_op;
    assign bus.err_timeout  = e_tmo;

endmodule

// File: tb/tb_cmd_packet_rx.sv
// Scoreboard bench for cmd_packet_rx: directed frames push expected events,
// a negedge monitor pops and compares every dispatch pulse or error pulse.
module tb_cmd_packet_rx;

    localparam int PS  = 256;
    localparam int ND  = 4;
    localparam int TMO = 300;

    localparam logic [3:0] E_LEN = 4'b0001;
    localparam logic [3:0] E_CS  = 4'b0010;
    localparam logic [3:0] E_OP  = 4'b0100;
    localparam logic [3:0] E_TO  = 4'b1000;

    typedef struct {
        logic [3:0] pulse;
        logic [3:0] err;
        logic [7:0] len;
        logic [7:0] op;
        int         lidx;
        logic [7:0] lbyte;
    } exp_t;

    logic CLK;
    logic rst;
    logic hold;
    int   busy_len;
    int   bcnt [ND];
    int   checks;
    int   failures;
    exp_t q[$];
    logic [7:0] fr[$];

    cmd_packet_rx_if #(.PACKET_SIZE(PS), .NUM_DST(ND)) bus ();

    cmd_packet_rx #(
        .PACKET_SIZE(PS),
        .NUM_DST    (ND),
        .SOF_BYTE   (8'hA5),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Loader model: BUSY rises right after the dispatch pulse and stays for busy_len cycles.
    always @(posedge CLK) begin
        #1;
        for (int k = 0; k < ND; k++) begin
            if (rst)                         bcnt[k] = 0;
            else if (bus.begin_req_pulse[k]) bcnt[k] = busy_len;
            else if (bcnt[k] > 0)            bcnt[k] = bcnt[k] - 1;
            bus.dst_busy[k] = hold || (bcnt[k] > 0);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge CLK) begin
        logic [3:0] ev;
        exp_t e;
        ev = {bus.err_timeout, bus.err_opcode, bus.err_csum, bus.err_len};
        if (!rst && (|bus.begin_req_pulse || |ev)) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event pulse=%b err=%b", bus.begin_req_pulse, ev);
            end else begin
                e = q.pop_front();
                if (bus.begin_req_pulse !== e.pulse || ev !== e.err) begin
                    failures++;
                    $display("FAIL event pulse=%b err=%b required pulse=%b err=%b",
                             bus.begin_req_pulse, ev, e.pulse, e.err);
                end else if (|e.pulse) begin
                    checks++;
                    if (bus.begin_len !== e.len ||
                        bus.begin_packet[8*2 +: 8] !== e.op ||
                        bus.begin_packet[8*e.lidx +: 8] !== e.lbyte) begin
                        failures++;
                        $display("FAIL payload len=%h op=%h last=%h required %h %h %h",
                                 bus.begin_len, bus.begin_packet[8*2 +: 8],
                                 bus.begin_packet[8*e.lidx +: 8], e.len, e.op, e.lbyte);
                    end
                end
            end
        end
    end

    task automatic expect_ev(input logic [3:0] p, input logic [3:0] er, input logic [7:0] l,
                             input logic [7:0] o, input int li, input logic [7:0] lb);
        exp_t e;
        e.pulse = p;
        e.err   = er;
        e.len   = l;
        e.op    = o;
        e.lidx  = li;
        e.lbyte = lb;
        q.push_back(e);
    endtask

    task automatic send_fr();
        for (int i = 0; i < fr.size(); i++) begin
            int n;
            n = 0;
            bus.rx_data  = fr[i];
            bus.rx_valid = 1'b1;
            while (!bus.rx_ready && n < 100) begin
                @(negedge CLK);
                n++;
            end
            if (n >= 100) begin
                checks++;
                failures++;
                $display("FAIL send_stall byte=%0d actual=stalled required=accepted", i);
            end
            @(negedge CLK);
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic edge_frame(input logic [7:0] csum);
        fr = '{8'hA5, 8'h0A, 8'h02, 8'h01, 8'h03, 8'h00, 8'h01, 8'h00,
               8'h02, 8'h00, 8'h03, csum};
    endtask

    // Called on the dispatch cycle; rx_ready must stay low until the loader drops BUSY.
    task automatic wait_release(input string name, input int k);
        int n;
        int bad;
        n = 0;
        bad = 0;
        if (bus.rx_ready) bad++;
        @(negedge CLK);
        while (bus.dst_busy[k] && n < 50) begin
            if (bus.rx_ready) bad++;
            @(negedge CLK);
            n++;
        end
        chk({name, "_busy_seen"}, (n > 0 && n < 50), 1);
        chk({name, "_ready_low"}, bad + (bus.rx_ready ? 1 : 0), 0);
        @(negedge CLK);
        chk({name, "_ready_back"}, {bus.rx_ready, bus.BUSY}, 2'b10);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_ready_busy"}, {bus.rx_ready, bus.BUSY}, 2'b10);
        chk({name, "_len"}, bus.begin_len, 0);
        chk({name, "_pkt"}, |bus.begin_packet, 0);
        chk({name, "_pulse_err"}, {bus.begin_req_pulse, bus.err_timeout,
            bus.err_opcode, bus.err_csum, bus.err_len}, 0);
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        hold     = 1'b0;
        busy_len = 5;
        rst      = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.dst_busy = '0;
        repeat (3) @(negedge CLK);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge CLK);

        edge_frame(8'h00);
        expect_ev(4'b0100, 4'b0000, 8'h0A, 8'h02, 11, 8'h00);
        send_fr();
        wait_release("edge", 2);

        edge_frame(8'h5A);
        expect_ev(4'b0000, E_CS, 8'h0A, 8'h02, 11, 8'h5A);
        send_fr();
        chk("csum_ready", {bus.rx_ready, bus.BUSY}, 2'b10);

        fr = '{8'hA5, 8'h01};
        expect_ev(4'b0000, E_LEN, 8'h01, 8'h00, 1, 8'h01);
        send_fr();
        chk("len1_ready", {bus.rx_ready, bus.BUSY}, 2'b10);

        fr = '{8'hA5, 8'hFF};
        expect_ev(4'b0000, E_LEN, 8'hFF, 8'h00, 1, 8'hFF);
        send_fr();
        chk("lenff_ready", {bus.rx_ready, bus.BUSY}, 2'b10);

        fr = '{8'hA5, 8'hFE, 8'h01};
        for (int i = 0; i < 252; i++) fr.push_back(8'h00);
        fr.push_back(8'h01);
        expect_ev(4'b0010, 4'b0000, 8'hFE, 8'h01, 255, 8'h01);
        send_fr();
        wait_release("lenfe", 1);

        fr = '{8'hA5, 8'h02, 8'h00, 8'h00};
        expect_ev(4'b0001, 4'b0000, 8'h02, 8'h00, 3, 8'h00);
        send_fr();
        wait_release("len2", 0);

        fr = '{8'hA5, 8'h03, 8'h07, 8'h11, 8'h16};
        expect_ev(4'b0000, E_OP, 8'h03, 8'h07, 4, 8'h16);
        send_fr();
        chk("opcode_ready", {bus.rx_ready, bus.BUSY}, 2'b10);

        fr = '{8'hA5, 8'h04, 8'h03, 8'hA5, 8'hA5, 8'h03};
        expect_ev(4'b1000, 4'b0000, 8'h04, 8'h03, 5, 8'h03);
        send_fr();
        wait_release("sof_data", 3);

        edge_frame(8'h00);
        fr.push_front(8'h13);
        fr.push_front(8'h00);
        expect_ev(4'b0100, 4'b0000, 8'h0A, 8'h02, 11, 8'h00);
        send_fr();
        wait_release("garbage", 2);

        fr = '{8'hA5, 8'h0A, 8'h02};
        expect_ev(4'b0000, E_TO, 8'h0A, 8'h02, 2, 8'h02);
        send_fr();
        n = 0;
        while (!bus.err_timeout && n < TMO + 20) begin
            @(negedge CLK);
            n++;
        end
        chk("timeout_lat", (n >= TMO - 1 && n <= TMO + 1), 1);
        @(negedge CLK);
        chk("timeout_ready", {bus.rx_ready, bus.BUSY}, 2'b10);

        hold = 1'b1;
        edge_frame(8'h00);
        expect_ev(4'b0100, 4'b0000, 8'h0A, 8'h02, 11, 8'h00);
        send_fr();
        repeat (4) @(negedge CLK);
        chk("wait_hold", {bus.rx_ready, bus.BUSY}, 2'b01);
        rst = 1'b1;
        @(negedge CLK);
        chk_reset("midwait_rst");
        hold = 1'b0;
        rst  = 1'b0;
        @(negedge CLK);

        edge_frame(8'h00);
        expect_ev(4'b0100, 4'b0000, 8'h0A, 8'h02, 11, 8'h00);
        send_fr();
        wait_release("after_rst", 2);

        repeat (5) @(negedge CLK);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
